endnode_vc_link_ctrl: RTL and testbench
=======================================

Name: endnode_vc_link_ctrl

Overview:
Parametrised link-level controller for the endnode, placed between the switch-side port and the phy TX/RX managers.
- Generalises the single-VC endnode glue to NUM_VC virtual channels.
- Per VC, it tracks transmit credits, queues owed credit-return (GRTCRED) commas, and keeps a saturating CRC-fail counter.
- Reports one sticky RX error status per packet.

Parameters:
NUM_VC, 2, number of virtual channels (>=1)
MAX_CREDIT, 8, credits per VC at reset; also the credit ceiling
CRED_W, $clog2(MAX_CREDIT+1), credit/owed counter width
CNT_W, 16, CRC-fail counter width per VC
VC_W, (NUM_VC>1 ? $clog2(NUM_VC) : 1), VC index width

Ports:
CLK  in  1  clock
RST  in  1  reset; one clock; reset is asynchronous and active-high
sw_start_tx  in  1  switch requests to start a data packet
sw_vc_tx  in  VC_W  VC of the requested packet
sw_accept_tx  out  1  start accepted this cycle (combinational)
sw_credit_avail  out  NUM_VC  bit v = credit_cnt[v] != 0
phy_tx_busy  in  1  phy TX manager cannot accept a new write
phy_data_write  out  1  start data packet on phy TX (pulse)
phy_grtcred_write  out  1  send GRTCRED comma (pulse)
phy_grtcred_vc  out  VC_W  VC of the comma being sent
buf_free  in  NUM_VC  local RX buffer freed one slot on VC v (pulse)
phy_rx_done  in  1  RX flit/comma decoded
phy_rx_comma_sel  in  comma_sel_t  decoded comma type
phy_rx_vc  in  VC_W  VC field of the received comma/packet
phy_rx_packet_done  in  1  last flit of an RX packet
phy_rx_crc_corr  in  1  CRC of the finishing packet correct
phy_rx_err  in  1  phy/uart error this cycle
pkt_err_valid  out  1  pulse on RX packet end
pkt_err  out  1  packet saw an error (valid with pkt_err_valid)
crc_fail_cnt  out  NUM_VC*CNT_W  per-VC CRC-fail count
credit_cnt  out  NUM_VC*CRED_W  per-VC TX credits
proto_err  out  1  sticky; credit overflow was received

Behaviour:
- Reset values: credit_cnt[v]=MAX_CREDIT; owed[v]=0; crc_fail_cnt=0; err_store=0; proto_err=0; rr_ptr=0; all pulse outputs 0.
- Credit return arbitration (combinational, same cycle):
  - grant_req = any owed[v] != 0 and !phy_tx_busy.
  - The granted VC is the first VC with owed!=0 searching from rr_ptr upward, wrapping.
  - phy_grtcred_write=grant_req; phy_grtcred_vc=granted VC.
  - rr_ptr <= granted VC + 1 (mod NUM_VC) on the next edge.
- Data start:
  - sw_accept_tx = sw_start_tx & credit_cnt[sw_vc_tx]!=0 & !phy_tx_busy & !grant_req. Credit returns take priority to avoid deadlock.
  - phy_data_write = sw_accept_tx.
  - The switch holds sw_start_tx until accepted.
- Credit counter v, next edge:
  - -1 on accept for v; +1 on phy_rx_done & comma_sel==GRTCRED_SEL & phy_rx_vc==v.
  - Both in the same cycle: unchanged.
  - An increment at MAX_CREDIT holds the value and sets proto_err (cleared only by RST).
  - Grants with phy_rx_vc >= NUM_VC are ignored.
- Owed counter v:
  - +1 on buf_free[v]; -1 when granted.
  - Both in the same cycle: unchanged.
  - Saturates at MAX_CREDIT; no wrap.
- CRC counter v: +1 on phy_rx_packet_done & !phy_rx_crc_corr & phy_rx_vc==v. Saturates at all-ones.
- Sticky error:
  - err_store <= err_store | phy_rx_err.
  - On phy_rx_packet_done: pkt_err_valid=1 and pkt_err=err_store|phy_rx_err (combinational), and err_store <= 0 on that edge. An error in the last cycle belongs to the finishing packet.
- Latency: start/comma writes are combinational from inputs; counters update 1 cycle later.
- RST mid-packet: all state returns to reset values immediately; no write pulses while RST is high.

Decomposition:
- chiplet_types_pkg / phy_types_pkg (existing): comma_sel_t and GRTCRED_SEL.
- Add a vc_credit_t typedef and a NUM_VC_DEFAULT constant to chiplet_types_pkg.
- Sub-module vc_rr_arbiter (NUM_VC request vector to one-hot grant plus index, with rotating pointer). It is reused by the switch.
- Per-VC counters are a generate loop in the top module.

Test Plan:
1. Reset, then 8 accepted starts on VC0 -> credit_cnt[0]=0, sw_credit_avail=2'b10; a 9th sw_start_tx gets sw_accept_tx=0.
2. With credit_cnt[1]=3, a GRTCRED for VC1 and an accepted start on VC1 in the same cycle -> credit_cnt[1] stays 3; GRTCRED at 8 -> stays 8, proto_err=1.
3. buf_free=2'b11 twice, phy idle -> 4 grants alternating VC0,VC1,VC0,VC1; a concurrent sw_start_tx is accepted only after owed is all zero.
4. phy_tx_busy=1 for 5 cycles with owed[0]=2 -> no writes; first cycle after busy drops -> phy_grtcred_write=1 with VC0.
5. phy_rx_err mid-packet, then packet_done -> pkt_err_valid=1, pkt_err=1; next packet error-free -> pkt_err=0.
6. 3 RX packets on VC1 with crc_corr=0 -> crc_fail_cnt[1]=3, [0]=0; preload to 16'hFFFF, one more failure -> holds 16'hFFFF.

Source files
------------

// File: rtl/chiplet_types_pkg.sv
// Shared chiplet link types: comma encodings seen by the phy RX decoder and
// default virtual-channel sizing used by the endnode and switch.
package chiplet_types_pkg;

  typedef enum logic [1:0] {
    NONE_SEL      = 2'd0,
    START_PKT_SEL = 2'd1,
    END_PKT_SEL   = 2'd2,
    GRTCRED_SEL   = 2'd3
  } comma_sel_t;

  localparam int NUM_VC_DEFAULT     = 2;
  localparam int MAX_CREDIT_DEFAULT = 8;
  localparam int CRED_W_DEFAULT     = $clog2(MAX_CREDIT_DEFAULT + 1);

  typedef logic [CRED_W_DEFAULT-1:0] vc_credit_t;

  // Request/grant pair as seen by a rotating-priority arbiter client.
  typedef struct packed {
    logic valid;
    logic last;
  } vc_req_t;

endpackage

// File: rtl/vc_rr_arbiter.sv
// Rotating-priority arbiter: picks the first requester at or above the pointer,
// wrapping, and moves the pointer just past the winner when the grant is used.
module vc_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] rr_ptr
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
      cand = sum[IDX_W-1:0];
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt_idx    = cand;
        gnt[cand]  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/endnode_vc_link_ctrl.sv
// Endnode link controller: per-VC TX credits, owed credit-return commas,
// CRC-fail counters and a per-packet sticky RX error report.
module endnode_vc_link_ctrl
  import chiplet_types_pkg::*;
#(
  parameter int NUM_VC     = NUM_VC_DEFAULT,
  parameter int MAX_CREDIT = MAX_CREDIT_DEFAULT,
  parameter int CRED_W     = $clog2(MAX_CREDIT + 1),
  parameter int CNT_W      = 16,
  parameter int VC_W       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     sw_start_tx,
  input  logic [VC_W-1:0]          sw_vc_tx,
  output logic                     sw_accept_tx,
  output logic [NUM_VC-1:0]        sw_credit_avail,
  input  logic                     phy_tx_busy,
  output logic                     phy_data_write,
  output logic                     phy_grtcred_write,
  output logic [VC_W-1:0]          phy_grtcred_vc,
  input  logic [NUM_VC-1:0]        buf_free,
  input  logic                     phy_rx_done,
  input  comma_sel_t               phy_rx_comma_sel,
  input  logic [VC_W-1:0]          phy_rx_vc,
  input  logic                     phy_rx_packet_done,
  input  logic                     phy_rx_crc_corr,
  input  logic                     phy_rx_err,
  output logic                     pkt_err_valid,
  output logic                     pkt_err,
  output logic [NUM_VC*CNT_W-1:0]  crc_fail_cnt,
  output logic [NUM_VC*CRED_W-1:0] credit_cnt,
  output logic                     proto_err
);

  // Handshake: the switch holds sw_start_tx/sw_vc_tx until sw_accept_tx is
  // seen high in the same cycle; phy_data_write and phy_grtcred_write are
  // single-cycle pulses that the phy TX manager takes whenever phy_tx_busy is
  // low. Nothing is issued while RST is high.

  logic [NUM_VC-1:0] owed_nz;
  logic [NUM_VC-1:0] credit_nz;
  logic [NUM_VC-1:0] gnt_onehot;
  logic [NUM_VC-1:0] ovf_v;
  logic [VC_W-1:0]   gnt_idx;
  logic [VC_W-1:0]   rr_ptr;
  logic              gnt_any;
  logic              grant_req;
  logic              sel_credit_nz;
  logic              err_store;

  vc_rr_arbiter #(
    .N     (NUM_VC),
    .IDX_W (VC_W)
  ) u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .req       (owed_nz),
    .advance   (grant_req),
    .gnt       (gnt_onehot),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_any),
    .rr_ptr    (rr_ptr)
  );

  // Credit returns win over data starts so a peer waiting on credits never stalls.
  assign grant_req         = gnt_any & ~phy_tx_busy & ~RST;
  assign phy_grtcred_write = grant_req;
  assign phy_grtcred_vc    = gnt_idx;

  always_comb begin
    sel_credit_nz = 1'b0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (sw_vc_tx == VC_W'(v)) sel_credit_nz = credit_nz[v];
    end
  end

  assign sw_accept_tx    = sw_start_tx & sel_credit_nz & ~phy_tx_busy & ~grant_req & ~RST;
  assign phy_data_write  = sw_accept_tx;
  assign sw_credit_avail = credit_nz;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [CRED_W-1:0] credit_q;
    logic [CRED_W-1:0] owed_q;
    logic [CNT_W-1:0]  crc_q;
    logic              cred_inc;
    logic              cred_dec;
    logic              owed_inc;
    logic              owed_dec;
    logic              crc_inc;

    assign cred_inc = phy_rx_done && (phy_rx_comma_sel == GRTCRED_SEL) &&
                      (phy_rx_vc == VC_W'(v));
    assign cred_dec = sw_accept_tx && (sw_vc_tx == VC_W'(v));
    assign owed_inc = buf_free[v];
    assign owed_dec = grant_req && gnt_onehot[v];
    assign crc_inc  = phy_rx_packet_done && !phy_rx_crc_corr && (phy_rx_vc == VC_W'(v));

    // A lone return at the ceiling means the peer returned more than it was given.
    assign ovf_v[v] = cred_inc && !cred_dec && (credit_q == CRED_W'(MAX_CREDIT));

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        credit_q <= CRED_W'(MAX_CREDIT);
      end else if (cred_inc && !cred_dec && (credit_q != CRED_W'(MAX_CREDIT))) begin
        credit_q <= credit_q + CRED_W'(1);
      end else if (cred_dec && !cred_inc) begin
        credit_q <= credit_q - CRED_W'(1);
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        owed_q <= '0;
      end else if (owed_inc && !owed_dec && (owed_q != CRED_W'(MAX_CREDIT))) begin
        owed_q <= owed_q + CRED_W'(1);
      end else if (owed_dec && !owed_inc) begin
        owed_q <= owed_q - CRED_W'(1);
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        crc_q <= '0;
      end else if (crc_inc && (crc_q != '1)) begin
        crc_q <= crc_q + CNT_W'(1);
      end
    end

    assign credit_nz[v] = (credit_q != '0);
    assign owed_nz[v]   = (owed_q != '0);
    assign credit_cnt[v*CRED_W +: CRED_W] = credit_q;
    assign crc_fail_cnt[v*CNT_W +: CNT_W] = crc_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      proto_err <= 1'b0;
    end else if (|ovf_v) begin
      proto_err <= 1'b1;
    end
  end

  // An error arriving on the last flit belongs to the packet that is ending.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_store <= 1'b0;
    end else if (phy_rx_packet_done) begin
      err_store <= 1'b0;
    end else begin
      err_store <= err_store | phy_rx_err;
    end
  end

  assign pkt_err_valid = phy_rx_packet_done & ~RST;
  assign pkt_err       = pkt_err_valid & (err_store | phy_rx_err);

endmodule

// File: tb/tb_endnode_vc_link_ctrl.sv
// Bench for endnode_vc_link_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the link rules.
module tb_endnode_vc_link_ctrl;
  import chiplet_types_pkg::*;

  localparam int NUM_VC     = 2;
  localparam int MAX_CREDIT = 8;
  localparam int CRED_W     = 4;
  localparam int CNT_W      = 16;
  localparam int VC_W       = 1;
  localparam int CRC_MAX    = 65535;

  logic                     CLK = 1'b0;
  logic                     RST;
  logic                     sw_start_tx;
  logic [VC_W-1:0]          sw_vc_tx;
  logic                     sw_accept_tx;
  logic [NUM_VC-1:0]        sw_credit_avail;
  logic                     phy_tx_busy;
  logic                     phy_data_write;
  logic                     phy_grtcred_write;
  logic [VC_W-1:0]          phy_grtcred_vc;
  logic [NUM_VC-1:0]        buf_free;
  logic                     phy_rx_done;
  comma_sel_t               phy_rx_comma_sel;
  logic [VC_W-1:0]          phy_rx_vc;
  logic                     phy_rx_packet_done;
  logic                     phy_rx_crc_corr;
  logic                     phy_rx_err;
  logic                     pkt_err_valid;
  logic                     pkt_err;
  logic [NUM_VC*CNT_W-1:0]  crc_fail_cnt;
  logic [NUM_VC*CRED_W-1:0] credit_cnt;
  logic                     proto_err;

  always #5 CLK = ~CLK;

  endnode_vc_link_ctrl #(
    .NUM_VC     (NUM_VC),
    .MAX_CREDIT (MAX_CREDIT),
    .CRED_W     (CRED_W),
    .CNT_W      (CNT_W),
    .VC_W       (VC_W)
  ) dut (
    .CLK                (CLK),
    .RST                (RST),
    .sw_start_tx        (sw_start_tx),
    .sw_vc_tx           (sw_vc_tx),
    .sw_accept_tx       (sw_accept_tx),
    .sw_credit_avail    (sw_credit_avail),
    .phy_tx_busy        (phy_tx_busy),
    .phy_data_write     (phy_data_write),
    .phy_grtcred_write  (phy_grtcred_write),
    .phy_grtcred_vc     (phy_grtcred_vc),
    .buf_free           (buf_free),
    .phy_rx_done        (phy_rx_done),
    .phy_rx_comma_sel   (phy_rx_comma_sel),
    .phy_rx_vc          (phy_rx_vc),
    .phy_rx_packet_done (phy_rx_packet_done),
    .phy_rx_crc_corr    (phy_rx_crc_corr),
    .phy_rx_err         (phy_rx_err),
    .pkt_err_valid      (pkt_err_valid),
    .pkt_err            (pkt_err),
    .crc_fail_cnt       (crc_fail_cnt),
    .credit_cnt         (credit_cnt),
    .proto_err          (proto_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_credit[NUM_VC];
  int m_owed[NUM_VC];
  int m_crc[NUM_VC];
  int m_rr;
  bit m_err;
  bit m_proto;

  // Model predictions for the current cycle
  bit e_grant;
  int e_gvc;
  bit e_accept;
  bit e_pkt_valid;
  bit e_pkt_err;

  function automatic void model_reset();
    for (int v = 0; v < NUM_VC; v++) begin
      m_credit[v] = MAX_CREDIT;
      m_owed[v]   = 0;
      m_crc[v]    = 0;
    end
    m_rr    = 0;
    m_err   = 0;
    m_proto = 0;
  endfunction

  function automatic void model_comb();
    e_grant = 0;
    e_gvc   = 0;
    if (!RST && !phy_tx_busy) begin
      for (int i = 0; i < NUM_VC; i++) begin
        int v;
        v = (m_rr + i) % NUM_VC;
        if (!e_grant && m_owed[v] > 0) begin
          e_grant = 1;
          e_gvc   = v;
        end
      end
    end
    e_accept = !RST && sw_start_tx && (int'(sw_vc_tx) < NUM_VC) &&
               (m_credit[sw_vc_tx] > 0) && !phy_tx_busy && !e_grant;
    e_pkt_valid = !RST && phy_rx_packet_done;
    e_pkt_err   = e_pkt_valid && (m_err || phy_rx_err);
  endfunction

  function automatic void model_update();
    if (RST) begin
      model_reset();
      return;
    end
    if (e_grant) begin
      m_owed[e_gvc] = m_owed[e_gvc] - 1;
      m_rr = (e_gvc + 1) % NUM_VC;
    end
    for (int v = 0; v < NUM_VC; v++) begin
      if (buf_free[v] && m_owed[v] < MAX_CREDIT) m_owed[v] = m_owed[v] + 1;
    end
    if (e_accept) m_credit[sw_vc_tx] = m_credit[sw_vc_tx] - 1;
    if (phy_rx_done && phy_rx_comma_sel == GRTCRED_SEL && int'(phy_rx_vc) < NUM_VC) begin
      if (m_credit[phy_rx_vc] == MAX_CREDIT) m_proto = 1;
      else m_credit[phy_rx_vc] = m_credit[phy_rx_vc] + 1;
    end
    if (phy_rx_packet_done && !phy_rx_crc_corr && int'(phy_rx_vc) < NUM_VC &&
        m_crc[phy_rx_vc] < CRC_MAX)
      m_crc[phy_rx_vc] = m_crc[phy_rx_vc] + 1;
    m_err = phy_rx_packet_done ? 1'b0 : (m_err | phy_rx_err);
  endfunction

  function automatic int dut_credit(int v);
    return int'(credit_cnt[v*CRED_W +: CRED_W]);
  endfunction

  function automatic int dut_crc(int v);
    return int'(crc_fail_cnt[v*CNT_W +: CNT_W]);
  endfunction

  task automatic tick();
    model_comb();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    sw_start_tx        = 1'b0;
    sw_vc_tx           = '0;
    phy_tx_busy        = 1'b0;
    buf_free           = '0;
    phy_rx_done        = 1'b0;
    phy_rx_comma_sel   = NONE_SEL;
    phy_rx_vc          = '0;
    phy_rx_packet_done = 1'b0;
    phy_rx_crc_corr    = 1'b1;
    phy_rx_err         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    sw_start_tx        = 1'b1;
    buf_free           = 2'b11;
    phy_rx_packet_done = 1'b1;
    #1;
    checks++;
    if (sw_accept_tx !== 1'b0 || phy_data_write !== 1'b0) begin
      failures++; $display("FAIL reset_accept: got %b/%b expected 0/0", sw_accept_tx, phy_data_write);
    end
    checks++;
    if (phy_grtcred_write !== 1'b0 || pkt_err_valid !== 1'b0) begin
      failures++; $display("FAIL reset_pulses: got %b/%b expected 0/0", phy_grtcred_write, pkt_err_valid);
    end
    tick();
    checks++;
    if (credit_cnt !== {4'd8, 4'd8} || sw_credit_avail !== 2'b11) begin
      failures++; $display("FAIL reset_credit: got %h/%b expected 88/11", credit_cnt, sw_credit_avail);
    end
    checks++;
    if (crc_fail_cnt !== '0 || proto_err !== 1'b0) begin
      failures++; $display("FAIL reset_counters: got %h/%b expected 0/0", crc_fail_cnt, proto_err);
    end
    idle_inputs();
    RST = 1'b0;
    #1;
    checks++;
    if (phy_grtcred_write !== 1'b0) begin
      failures++; $display("FAIL reset_owed: got grtcred_write=%b expected 0", phy_grtcred_write);
    end
  endtask

  task automatic test_credit_exhaust();
    sw_start_tx = 1'b1;
    sw_vc_tx    = 1'b0;
    for (int i = 0; i < MAX_CREDIT; i++) begin
      #1;
      checks++;
      if (sw_accept_tx !== 1'b1 || phy_data_write !== 1'b1) begin
        failures++; $display("FAIL exhaust_accept%0d: got %b/%b expected 1/1", i, sw_accept_tx, phy_data_write);
      end
      tick();
    end
    checks++;
    if (dut_credit(0) !== 0 || sw_credit_avail !== 2'b10) begin
      failures++; $display("FAIL exhaust_credit: got %0d/%b expected 0/10", dut_credit(0), sw_credit_avail);
    end
    checks++;
    if (sw_accept_tx !== 1'b0) begin
      failures++; $display("FAIL exhaust_ninth: got accept=%b expected 0", sw_accept_tx);
    end
    sw_start_tx = 1'b0;
  endtask

  task automatic test_credit_return();
    sw_start_tx = 1'b1;
    sw_vc_tx    = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (dut_credit(1) !== 3) begin
      failures++; $display("FAIL return_pre: got credit1=%0d expected 3", dut_credit(1));
    end
    phy_rx_done      = 1'b1;
    phy_rx_comma_sel = GRTCRED_SEL;
    phy_rx_vc        = 1'b1;
    #1;
    checks++;
    if (sw_accept_tx !== 1'b1) begin
      failures++; $display("FAIL return_same_accept: got %b expected 1", sw_accept_tx);
    end
    tick();
    checks++;
    if (dut_credit(1) !== 3) begin
      failures++; $display("FAIL return_same_cycle: got credit1=%0d expected 3", dut_credit(1));
    end
    sw_start_tx = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (dut_credit(1) !== 8 || proto_err !== 1'b0) begin
      failures++; $display("FAIL return_to_max: got %0d/%b expected 8/0", dut_credit(1), proto_err);
    end
    tick();
    checks++;
    if (dut_credit(1) !== 8 || proto_err !== 1'b1) begin
      failures++; $display("FAIL return_overflow: got %0d/%b expected 8/1", dut_credit(1), proto_err);
    end
    idle_inputs();
    tick();
    checks++;
    if (proto_err !== 1'b1) begin
      failures++; $display("FAIL proto_sticky: got %b expected 1", proto_err);
    end
  endtask

  task automatic test_rr_grants();
    int exp_vc[4] = '{0, 1, 0, 1};
    do_reset();
    buf_free = 2'b11;
    #1;
    checks++;
    if (phy_grtcred_write !== 1'b0) begin
      failures++; $display("FAIL rr_first: got grtcred_write=%b expected 0", phy_grtcred_write);
    end
    tick();
    sw_start_tx = 1'b1;
    sw_vc_tx    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (phy_grtcred_write !== 1'b1 || int'(phy_grtcred_vc) !== exp_vc[i] || sw_accept_tx !== 1'b0) begin
        failures++;
        $display("FAIL rr_grant%0d: got w=%b vc=%0d acc=%b expected 1/%0d/0",
                 i, phy_grtcred_write, phy_grtcred_vc, sw_accept_tx, exp_vc[i]);
      end
      tick();
      buf_free = 2'b00;
    end
    #1;
    checks++;
    if (phy_grtcred_write !== 1'b0 || sw_accept_tx !== 1'b1) begin
      failures++; $display("FAIL rr_drain: got w=%b acc=%b expected 0/1", phy_grtcred_write, sw_accept_tx);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_busy();
    do_reset();
    phy_tx_busy = 1'b1;
    sw_start_tx = 1'b1;
    sw_vc_tx    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      buf_free = (i < 2) ? 2'b01 : 2'b00;
      #1;
      checks++;
      if (phy_grtcred_write !== 1'b0 || phy_data_write !== 1'b0) begin
        failures++; $display("FAIL busy_hold%0d: got %b/%b expected 0/0", i, phy_grtcred_write, phy_data_write);
      end
      tick();
    end
    phy_tx_busy = 1'b0;
    sw_start_tx = 1'b0;
    #1;
    checks++;
    if (phy_grtcred_write !== 1'b1 || phy_grtcred_vc !== 1'b0) begin
      failures++; $display("FAIL busy_release: got %b vc=%0d expected 1 vc=0", phy_grtcred_write, phy_grtcred_vc);
    end
    tick();
    tick();
    idle_inputs();
  endtask

  task automatic test_pkt_err();
    do_reset();
    phy_rx_err = 1'b1;
    #1;
    checks++;
    if (pkt_err_valid !== 1'b0) begin
      failures++; $display("FAIL err_mid_valid: got %b expected 0", pkt_err_valid);
    end
    tick();
    phy_rx_err = 1'b0;
    tick();
    phy_rx_packet_done = 1'b1;
    #1;
    checks++;
    if (pkt_err_valid !== 1'b1 || pkt_err !== 1'b1) begin
      failures++; $display("FAIL err_end: got %b/%b expected 1/1", pkt_err_valid, pkt_err);
    end
    tick();
    phy_rx_packet_done = 1'b0;
    tick();
    phy_rx_packet_done = 1'b1;
    #1;
    checks++;
    if (pkt_err_valid !== 1'b1 || pkt_err !== 1'b0) begin
      failures++; $display("FAIL err_clean: got %b/%b expected 1/0", pkt_err_valid, pkt_err);
    end
    tick();
    phy_rx_err = 1'b1;
    #1;
    checks++;
    if (pkt_err !== 1'b1) begin
      failures++; $display("FAIL err_last_cycle: got %b expected 1", pkt_err);
    end
    tick();
    phy_rx_err = 1'b0;
    #1;
    checks++;
    if (pkt_err !== 1'b0) begin
      failures++; $display("FAIL err_cleared: got %b expected 0", pkt_err);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_crc();
    do_reset();
    phy_rx_vc          = 1'b1;
    phy_rx_crc_corr    = 1'b0;
    phy_rx_packet_done = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (dut_crc(1) !== 3 || dut_crc(0) !== 0) begin
      failures++; $display("FAIL crc_count: got %0d/%0d expected 3/0", dut_crc(1), dut_crc(0));
    end
    for (int i = 0; i < CRC_MAX - 3; i++) tick();
    checks++;
    if (dut_crc(1) !== CRC_MAX) begin
      failures++; $display("FAIL crc_top: got %0d expected %0d", dut_crc(1), CRC_MAX);
    end
    tick();
    checks++;
    if (dut_crc(1) !== CRC_MAX || dut_crc(0) !== 0) begin
      failures++; $display("FAIL crc_saturate: got %0d/%0d expected %0d/0", dut_crc(1), dut_crc(0), CRC_MAX);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 500; n++) begin
      RST                = ($urandom_range(0, 99) == 0);
      sw_start_tx        = $urandom_range(0, 1);
      sw_vc_tx           = VC_W'($urandom_range(0, NUM_VC - 1));
      phy_tx_busy        = ($urandom_range(0, 3) == 0);
      buf_free           = NUM_VC'($urandom_range(0, 3));
      phy_rx_done        = $urandom_range(0, 1);
      phy_rx_comma_sel   = comma_sel_t'($urandom_range(0, 3));
      phy_rx_vc          = VC_W'($urandom_range(0, NUM_VC - 1));
      phy_rx_packet_done = ($urandom_range(0, 4) == 0);
      phy_rx_crc_corr    = $urandom_range(0, 1);
      phy_rx_err         = ($urandom_range(0, 5) == 0);
      #1;
      model_comb();
      checks++;
      if (sw_accept_tx !== e_accept || phy_data_write !== e_accept) begin
        failures++; $display("FAIL rnd_accept c%0d: got %b/%b expected %b", n, sw_accept_tx, phy_data_write, e_accept);
      end
      checks++;
      if (phy_grtcred_write !== e_grant || (e_grant && int'(phy_grtcred_vc) !== e_gvc)) begin
        failures++;
        $display("FAIL rnd_grant c%0d: got %b vc=%0d expected %b vc=%0d", n, phy_grtcred_write, phy_grtcred_vc, e_grant, e_gvc);
      end
      checks++;
      if (pkt_err_valid !== e_pkt_valid || pkt_err !== e_pkt_err) begin
        failures++; $display("FAIL rnd_pkt c%0d: got %b/%b expected %b/%b", n, pkt_err_valid, pkt_err, e_pkt_valid, e_pkt_err);
      end
      tick();
      for (int v = 0; v < NUM_VC; v++) begin
        checks++;
        if (dut_credit(v) !== m_credit[v] || sw_credit_avail[v] !== (m_credit[v] != 0)) begin
          failures++; $display("FAIL rnd_credit%0d c%0d: got %0d expected %0d", v, n, dut_credit(v), m_credit[v]);
        end
        checks++;
        if (dut_crc(v) !== m_crc[v]) begin
          failures++; $display("FAIL rnd_crc%0d c%0d: got %0d expected %0d", v, n, dut_crc(v), m_crc[v]);
        end
      end
      checks++;
      if (proto_err !== m_proto) begin
        failures++; $display("FAIL rnd_proto c%0d: got %b expected %b", n, proto_err, m_proto);
      end
    end
    RST = 1'b0;
    idle_inputs();
  endtask

  initial begin
    model_reset();
    idle_inputs();
    RST = 1'b1;
    test_reset();
    test_credit_exhaust();
    test_credit_return();
    test_rr_grants();
    test_busy();
    test_pkt_err();
    test_crc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
